// File: rtl/pipeline_hazard_controller_if.sv
// Hazard-controller bundle: decode/execute/memory hazard inputs and the pipeline-register controls.
// The master modport is the controller; the slave modport is the datapath that feeds and obeys it.
interface pipeline_hazard_controller_if #(
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned CNT_W      = 16
);
  logic [REG_ADDR_W-1:0] IF_ID_RegisterRs1;
  logic [REG_ADDR_W-1:0] IF_ID_RegisterRs2;
  logic                  IF_ID_UsesRs2;
  logic                  ID_EX_MemRead;
  logic [REG_ADDR_W-1:0] ID_EX_RegisterRd;
  logic                  EX_MEM_Branch;
  logic                  EX_MEM_Zero;
  logic                  mem_req;
  logic                  mem_ready;

  logic                  PCWrite;
  logic                  PCSrc;
  logic                  IF_ID_Write;
  logic                  ID_EX_Write;
  logic                  EX_MEM_Write;
  logic                  IF_ID_Flush;
  logic                  ID_EX_Flush;
  logic                  EX_MEM_Flush;
  logic                  MEM_WB_Flush;
  logic                  mem_timeout_err;
  logic [CNT_W-1:0]      stall_count;
  logic [CNT_W-1:0]      flush_count;

  modport master (
    input  IF_ID_RegisterRs1, IF_ID_RegisterRs2, IF_ID_UsesRs2, ID_EX_MemRead,
           ID_EX_RegisterRd, EX_MEM_Branch, EX_MEM_Zero, mem_req, mem_ready,
    output PCWrite, PCSrc, IF_ID_Write, ID_EX_Write, EX_MEM_Write, IF_ID_Flush,
           ID_EX_Flush, EX_MEM_Flush, MEM_WB_Flush, mem_timeout_err, stall_count, flush_count
  );

  modport slave (
    output IF_ID_RegisterRs1, IF_ID_RegisterRs2, IF_ID_UsesRs2, ID_EX_MemRead,
           ID_EX_RegisterRd, EX_MEM_Branch, EX_MEM_Zero, mem_req, mem_ready,
    input  PCWrite, PCSrc, IF_ID_Write, ID_EX_Write, EX_MEM_Write, IF_ID_Flush,
           ID_EX_Flush, EX_MEM_Flush, MEM_WB_Flush, mem_timeout_err, stall_count, flush_count
  );
endinterface

// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencer for the 5-stage RV64 pipeline: load-use, taken branch and memory wait/timeout.
// Define PERF_COUNTERS_EN to build the stall/flush counters; otherwise both counter outputs are 0.
module pipeline_hazard_controller #(
  parameter int unsigned REG_ADDR_W  = 5,
  parameter int unsigned MEM_TIMEOUT = 64,
  parameter int unsigned CNT_W       = 16
) (
  input logic                          clk,
  input logic                          reset,
  pipeline_hazard_controller_if.master hz
);
  localparam int unsigned           WAIT_W     = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0]     WAIT_ONE   = WAIT_W'(1);
  localparam logic [WAIT_W-1:0]     WAIT_LIMIT = WAIT_W'(MEM_TIMEOUT);
  localparam logic [REG_ADDR_W-1:0] REG_X0     = '0;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_ERROR    = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [WAIT_W-1:0] wait_cnt, wait_nxt, wait_inc;
  logic              err;
  logic              lu_hazard, br_taken, mem_stall;
  logic              freeze, resolve, lu_stall, br_flush, pc_write;

  assign lu_hazard = hz.ID_EX_MemRead && (hz.ID_EX_RegisterRd != REG_X0) &&
                     ((hz.ID_EX_RegisterRd == hz.IF_ID_RegisterRs1) ||
                      (hz.IF_ID_UsesRs2 && (hz.ID_EX_RegisterRd == hz.IF_ID_RegisterRs2)));
  assign br_taken  = hz.EX_MEM_Branch && hz.EX_MEM_Zero;
  assign mem_stall = hz.mem_req && !hz.mem_ready;
  assign wait_inc  = wait_cnt + WAIT_ONE;

  // freeze = whole front end held for memory/error; resolve = branch/load-use logic may act
  always_comb begin
    state_nxt = state;
    wait_nxt  = wait_cnt;
    freeze    = 1'b0;
    resolve   = 1'b0;
    case (state)
      ST_RUN: begin
        if (mem_stall) begin
          freeze    = 1'b1;
          wait_nxt  = WAIT_ONE;
          state_nxt = (WAIT_ONE == WAIT_LIMIT) ? ST_ERROR : ST_MEM_WAIT;
        end else begin
          resolve = 1'b1;
        end
      end
      ST_MEM_WAIT: begin
        if (!hz.mem_ready) begin
          freeze   = 1'b1;
          wait_nxt = wait_inc;
          if (wait_inc == WAIT_LIMIT) state_nxt = ST_ERROR;
        end else begin
          resolve   = 1'b1;
          wait_nxt  = '0;
          state_nxt = ST_RUN;
        end
      end
      ST_ERROR: freeze = 1'b1;
      default:  state_nxt = ST_RUN;
    endcase
    // Controls fall back to defaults the instant reset asserts, independent of the clock
    if (!reset) begin
      freeze  = 1'b0;
      resolve = 1'b0;
    end
  end

  assign br_flush = resolve && br_taken;
  assign lu_stall = resolve && !br_taken && lu_hazard;
  assign pc_write = !(freeze || lu_stall);

  assign hz.PCWrite         = pc_write;
  assign hz.PCSrc           = br_flush;
  assign hz.IF_ID_Write     = pc_write;
  assign hz.ID_EX_Write     = !freeze;
  assign hz.EX_MEM_Write    = !freeze;
  assign hz.IF_ID_Flush     = br_flush;
  assign hz.ID_EX_Flush     = br_flush || lu_stall;
  assign hz.EX_MEM_Flush    = br_flush;
  assign hz.MEM_WB_Flush    = freeze;
  assign hz.mem_timeout_err = err;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_RUN;
      wait_cnt <= '0;
      err      <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
      if (state_nxt == ST_ERROR) err <= 1'b1;
    end
  end

`ifdef PERF_COUNTERS_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  // Saturating counters: stalls are cycles with the PC held, flushes are taken branches
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (!pc_write && (stall_cnt != CNT_MAX)) stall_cnt <= stall_cnt + CNT_W'(1);
      if (br_flush && (flush_cnt != CNT_MAX))  flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

  assign hz.stall_count = stall_cnt;
  assign hz.flush_count = flush_cnt;
`else
  assign hz.stall_count = CNT_W'(0);
  assign hz.flush_count = CNT_W'(0);
`endif

endmodule

// File: doc/pipeline_hazard_controller.md
Name: pipeline_hazard_controller

Overview:
- Central stall/flush sequencer for the 5-stage RV64 pipeline. It sits beside the execute-stage forwarding logic and covers the hazards that forwarding cannot resolve: load-use dependencies, taken branches resolved in EX/MEM, and a multi-cycle data-memory handshake.
- It drives the write-enable and flush controls of PC, IF/ID, ID/EX, EX/MEM and MEM/WB.
- It runs a small FSM for memory wait, timeout and error handling.

Parameters:
- REG_ADDR_W, 5, register address width.
- MEM_TIMEOUT, 64, maximum number of MEM_WAIT cycles before a fatal error is declared.
- CNT_W, 16, width of the performance counters.

Ports:
- clk  input  1  pipeline clock
- reset  input  1  asynchronous, active-low reset
- IF_ID_RegisterRs1  input  REG_ADDR_W  rs1 of the instruction in decode
- IF_ID_RegisterRs2  input  REG_ADDR_W  rs2 of the instruction in decode
- IF_ID_UsesRs2  input  1  decode instruction reads rs2 (R-type, store, branch)
- ID_EX_MemRead  input  1  instruction in EX is a load
- ID_EX_RegisterRd  input  REG_ADDR_W  rd of the instruction in EX
- EX_MEM_Branch  input  1  instruction in MEM is a branch
- EX_MEM_Zero  input  1  zero flag for the branch in MEM
- mem_req  input  1  instruction in MEM accesses data memory
- mem_ready  input  1  data memory completes the access this cycle
- PCWrite  output  1  PC register enable
- PCSrc  output  1  select branch target (PCPlusImmShifted)
- IF_ID_Write  output  1  IF/ID enable
- ID_EX_Write  output  1  ID/EX enable
- EX_MEM_Write  output  1  EX/MEM enable
- IF_ID_Flush  output  1  clear IF/ID to NOP
- ID_EX_Flush  output  1  insert bubble into ID/EX
- EX_MEM_Flush  output  1  insert bubble into EX/MEM
- MEM_WB_Flush  output  1  insert bubble into MEM/WB
- mem_timeout_err  output  1  sticky fatal error flag
- stall_count  output  CNT_W  total stall cycles
- flush_count  output  CNT_W  total taken-branch flushes

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to RUN; counters and mem_timeout_err clear; the wait counter clears.
  - Outputs during reset: all *_Write=1, all *_Flush=0, PCSrc=0.
- Control outputs are a combinational function of the current state and the inputs, so they take effect in the same cycle as the triggering input. State, counters and error flag are registered on the rising edge of clk.
- Hazard terms:
  - lu_hazard = ID_EX_MemRead & (ID_EX_RegisterRd != 0) & (ID_EX_RegisterRd == IF_ID_RegisterRs1 | (IF_ID_UsesRs2 & ID_EX_RegisterRd == IF_ID_RegisterRs2)).
  - br_taken = EX_MEM_Branch & EX_MEM_Zero.
  - mem_stall = mem_req & !mem_ready.
- Priority, highest first: ERROR > mem_stall > br_taken > lu_hazard.
- RUN state:
  - mem_stall: PCWrite, IF_ID_Write, ID_EX_Write and EX_MEM_Write all 0; MEM_WB_Flush=1. Next state MEM_WAIT, wait counter set to 1.
  - Else br_taken: PCSrc=1, PCWrite=1, IF_ID_Flush=1, ID_EX_Flush=1, EX_MEM_Flush=1. Any lu_hazard in the same cycle is ignored. flush_count increments.
  - Else lu_hazard: PCWrite=0, IF_ID_Write=0, ID_EX_Flush=1, for exactly one cycle. The bubble clears ID_EX_MemRead on the next cycle.
  - Else: defaults.
- MEM_WAIT state:
  - While mem_ready=0: same freeze as the RUN mem_stall case; the wait counter increments.
  - On mem_ready=1: release all enables and return to RUN. br_taken and lu_hazard are evaluated in the same cycle exactly as in RUN.
  - A branch in EX/MEM is held by the freeze and resolves after release.
  - If the wait counter reaches MEM_TIMEOUT with mem_ready still 0, the next state is ERROR.
- ERROR state:
  - All *_Write=0, MEM_WB_Flush=1, mem_timeout_err=1.
  - The block stays in ERROR until reset. mem_ready is ignored.
- stall_count increments on every cycle in which PCWrite=0 (load-use, MEM_WAIT, ERROR).
- Both counters saturate at 2^CNT_W-1; they never wrap.
- Register address x0 never causes a load-use stall.

Optional Feature:
- Macro: PERF_COUNTERS_EN.
  - Defined: stall_count and flush_count are implemented as described above.
  - Undefined: no counter flops are built; both outputs are driven constant 0. All other behaviour is unchanged.

Test Plan:
- Load-use: ID_EX_MemRead=1, ID_EX_RegisterRd=5, IF_ID_RegisterRs1=5 -> one cycle with PCWrite=0, IF_ID_Write=0, ID_EX_Flush=1; next cycle (MemRead=0) all defaults. Repeat with Rd=0 -> no stall.
- Rs2 gating: Rd=7, Rs2=7, IF_ID_UsesRs2=0 -> no stall; IF_ID_UsesRs2=1 -> one-cycle stall.
- Branch priority: EX_MEM_Branch=1, EX_MEM_Zero=1 together with an active lu_hazard -> PCSrc=1, IF_ID_Flush=ID_EX_Flush=EX_MEM_Flush=1, PCWrite=1; flush_count goes 0->1.
- Memory wait: mem_req=1, mem_ready=0 for 3 cycles, then 1 -> all *_Write=0 and MEM_WB_Flush=1 for 3 cycles; release on the 4th cycle; stall_count=3 with PERF_COUNTERS_EN defined, 0 without it.
- Timeout: mem_req=1 and mem_ready=0 held for 70 cycles, MEM_TIMEOUT=64 -> ERROR entered after cycle 64, mem_timeout_err=1 and sticky. A later mem_ready=1 has no effect. Asserting reset=0 mid-cycle clears the state immediately and asynchronously.
- Reset mid-stall: reset=0 during MEM_WAIT -> outputs return to defaults without waiting for a clock edge; after release, state is RUN and counters are 0.
